// File: rtl/spi_xfer_arbiter_if.sv
// Bundle of requester-side and SPI-core-side signals for the two-requester SPI transfer arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus SPI core).
interface spi_xfer_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_rd;
  logic [7:0]  req_cs;
  logic [63:0] req_cmd;
  logic [63:0] req_addr;
  logic [11:0] req_cmd_len;
  logic [11:0] req_addr_len;
  logic [31:0] req_data_len;
  logic [31:0] req_dummy;
  logic [63:0] tx_data;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [31:0] rx_data;
  logic [1:0]  rx_valid;
  logic [1:0]  rx_ready;
  logic [1:0]  done;
  logic        done_err;
  logic [31:0] spi_cmd;
  logic [31:0] spi_addr;
  logic [5:0]  spi_cmd_len;
  logic [5:0]  spi_addr_len;
  logic [15:0] spi_data_len;
  logic [15:0] spi_dummy_rd;
  logic [15:0] spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd;
  logic        spi_wr;
  logic        spi_swrst;
  logic        spi_busy;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid;
  logic        spi_data_tx_ready;
  logic [31:0] spi_data_rx;
  logic        spi_data_rx_valid;
  logic        spi_data_rx_ready;

  modport slave (
    input  req_valid, req_rd, req_cs, req_cmd, req_addr, req_cmd_len, req_addr_len,
           req_data_len, req_dummy, tx_data, tx_valid, rx_ready, spi_busy,
           spi_data_tx_ready, spi_data_rx, spi_data_rx_valid,
    output req_ready, tx_ready, rx_data, rx_valid, done, done_err, spi_cmd, spi_addr,
           spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg,
           spi_rd, spi_wr, spi_swrst, spi_data_tx, spi_data_tx_valid, spi_data_rx_ready
  );

  modport master (
    output req_valid, req_rd, req_cs, req_cmd, req_addr, req_cmd_len, req_addr_len,
           req_data_len, req_dummy, tx_data, tx_valid, rx_ready, spi_busy,
           spi_data_tx_ready, spi_data_rx, spi_data_rx_valid,
    input  req_ready, tx_ready, rx_data, rx_valid, done, done_err, spi_cmd, spi_addr,
           spi_cmd_len, spi_addr_len, spi_data_len, spi_dummy_rd, spi_dummy_wr, spi_csreg,
           spi_rd, spi_wr, spi_swrst, spi_data_tx, spi_data_tx_valid, spi_data_rx_ready
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter sharing one SPI core between two requesters, with a per-transfer
// watchdog that resets the core and reports an errored completion on expiry.
module spi_xfer_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic           HCLK,
  input logic           HRESET,
  spi_xfer_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BSY, RUN, DONE} state_t;

  state_t      state_reg;
  logic        grant_reg;
  logic        last_grant_reg;
  logic [15:0] wdog_reg;
  logic [15:0] wdog_next;
  logic        timeout_hit;
  logic        pick;
  logic        active;

  logic [1:0]  req_ready_reg;
  logic [1:0]  done_reg;
  logic        done_err_reg;
  logic        spi_rd_reg;
  logic        spi_wr_reg;
  logic        spi_swrst_reg;
  logic [31:0] spi_cmd_reg;
  logic [31:0] spi_addr_reg;
  logic [5:0]  spi_cmd_len_reg;
  logic [5:0]  spi_addr_len_reg;
  logic [15:0] spi_data_len_reg;
  logic [15:0] spi_dummy_rd_reg;
  logic [15:0] spi_dummy_wr_reg;
  logic [3:0]  spi_csreg_reg;

  logic [31:0] cmd_arr      [2];
  logic [31:0] addr_arr     [2];
  logic [5:0]  cmd_len_arr  [2];
  logic [5:0]  addr_len_arr [2];
  logic [15:0] data_len_arr [2];
  logic [15:0] dummy_arr    [2];
  logic [3:0]  cs_arr       [2];
  logic [31:0] tx_arr       [2];
  logic [1:0]  tx_ready_c;
  logic [1:0]  rx_valid_c;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign cmd_arr[gi]      = bus.req_cmd[gi*32 +: 32];
      assign addr_arr[gi]     = bus.req_addr[gi*32 +: 32];
      assign cmd_len_arr[gi]  = bus.req_cmd_len[gi*6 +: 6];
      assign addr_len_arr[gi] = bus.req_addr_len[gi*6 +: 6];
      assign data_len_arr[gi] = bus.req_data_len[gi*16 +: 16];
      assign dummy_arr[gi]    = bus.req_dummy[gi*16 +: 16];
      assign cs_arr[gi]       = bus.req_cs[gi*4 +: 4];
      assign tx_arr[gi]       = bus.tx_data[gi*32 +: 32];
    end
  endgenerate

  // On a tie the requester that did not go last wins; a lone requester always wins.
  assign pick        = (bus.req_valid == 2'b11) ? ~last_grant_reg : bus.req_valid[1];
  // Compare the post-increment count so the reset pulse lands TIMEOUT+1 cycles after START.
  assign wdog_next   = wdog_reg + 16'd1;
  assign timeout_hit = (wdog_next == TIMEOUT);
  assign active      = (state_reg == START) || (state_reg == WAIT_BSY) || (state_reg == RUN);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg        <= IDLE;
      grant_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      wdog_reg         <= '0;
      req_ready_reg    <= '0;
      done_reg         <= '0;
      done_err_reg     <= 1'b0;
      spi_rd_reg       <= 1'b0;
      spi_wr_reg       <= 1'b0;
      spi_swrst_reg    <= 1'b0;
      spi_cmd_reg      <= '0;
      spi_addr_reg     <= '0;
      spi_cmd_len_reg  <= '0;
      spi_addr_len_reg <= '0;
      spi_data_len_reg <= '0;
      spi_dummy_rd_reg <= '0;
      spi_dummy_wr_reg <= '0;
      spi_csreg_reg    <= '0;
    end else begin
      req_ready_reg <= '0;
      done_reg      <= '0;
      done_err_reg  <= 1'b0;
      spi_rd_reg    <= 1'b0;
      spi_wr_reg    <= 1'b0;
      spi_swrst_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_reg            <= pick;
            req_ready_reg[pick]  <= 1'b1;
            state_reg            <= LOAD;
          end
        end
        LOAD: begin
          spi_cmd_reg      <= cmd_arr[grant_reg];
          spi_addr_reg     <= addr_arr[grant_reg];
          spi_cmd_len_reg  <= cmd_len_arr[grant_reg];
          spi_addr_len_reg <= addr_len_arr[grant_reg];
          spi_data_len_reg <= data_len_arr[grant_reg];
          spi_csreg_reg    <= cs_arr[grant_reg];
          spi_dummy_rd_reg <= bus.req_rd[grant_reg] ? dummy_arr[grant_reg] : 16'd0;
          spi_dummy_wr_reg <= bus.req_rd[grant_reg] ? 16'd0 : dummy_arr[grant_reg];
          spi_rd_reg       <= bus.req_rd[grant_reg];
          spi_wr_reg       <= ~bus.req_rd[grant_reg];
          state_reg        <= START;
        end
        START: begin
          wdog_reg  <= '0;
          state_reg <= WAIT_BSY;
        end
        WAIT_BSY, RUN: begin
          wdog_reg <= wdog_next;
          if (timeout_hit) begin
            spi_swrst_reg       <= 1'b1;
            done_reg[grant_reg] <= 1'b1;
            done_err_reg        <= 1'b1;
            state_reg           <= DONE;
          end else if (state_reg == WAIT_BSY) begin
            if (bus.spi_busy) state_reg <= RUN;
          end else if (!bus.spi_busy) begin
            done_reg[grant_reg] <= 1'b1;
            state_reg           <= DONE;
          end
        end
        DONE: begin
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_ready_c = '0;
    rx_valid_c = '0;
    if (active) begin
      tx_ready_c[grant_reg] = bus.spi_data_tx_ready;
      rx_valid_c[grant_reg] = bus.spi_data_rx_valid;
    end
  end

  assign bus.tx_ready          = tx_ready_c;
  assign bus.rx_valid          = rx_valid_c;
  assign bus.rx_data           = bus.spi_data_rx;
  assign bus.spi_data_tx       = active ? tx_arr[grant_reg] : 32'd0;
  assign bus.spi_data_tx_valid = active & bus.tx_valid[grant_reg];
  assign bus.spi_data_rx_ready = active & bus.rx_ready[grant_reg];

  assign bus.req_ready    = req_ready_reg;
  assign bus.done         = done_reg;
  assign bus.done_err     = done_err_reg;
  assign bus.spi_rd       = spi_rd_reg;
  assign bus.spi_wr       = spi_wr_reg;
  assign bus.spi_swrst    = spi_swrst_reg;
  assign bus.spi_cmd      = spi_cmd_reg;
  assign bus.spi_addr     = spi_addr_reg;
  assign bus.spi_cmd_len  = spi_cmd_len_reg;
  assign bus.spi_addr_len = spi_addr_len_reg;
  assign bus.spi_data_len = spi_data_len_reg;
  assign bus.spi_dummy_rd = spi_dummy_rd_reg;
  assign bus.spi_dummy_wr = spi_dummy_wr_reg;
  assign bus.spi_csreg    = spi_csreg_reg;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: one instance with the default watchdog limit and
// a second with TIMEOUT=16 for the stuck-busy case.
module tb_spi_xfer_arbiter;
  logic HCLK;
  logic HRESET;
  int   total;
  int   bad;
  int   idx;
  int   nd;
  int   hits;
  int   sw_k;
  int   sw_cnt;
  int   dn_k;
  logic [1:0] dn;
  logic       err;
  logic       err2;

  spi_xfer_arbiter_if bus ();
  spi_xfer_arbiter_if bus2 ();

  spi_xfer_arbiter dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));
  spi_xfer_arbiter #(.TIMEOUT(16'd16)) dut_to (.HCLK(HCLK), .HRESET(HRESET), .bus(bus2));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_bus();
    bus.req_valid = '0; bus.req_rd = '0; bus.req_cs = '0; bus.req_cmd = '0;
    bus.req_addr = '0; bus.req_cmd_len = '0; bus.req_addr_len = '0;
    bus.req_data_len = '0; bus.req_dummy = '0; bus.tx_data = '0; bus.tx_valid = '0;
    bus.rx_ready = '0; bus.spi_busy = 1'b0; bus.spi_data_tx_ready = 1'b0;
    bus.spi_data_rx = '0; bus.spi_data_rx_valid = 1'b0;
    bus2.req_valid = '0; bus2.req_rd = '0; bus2.req_cs = '0; bus2.req_cmd = '0;
    bus2.req_addr = '0; bus2.req_cmd_len = '0; bus2.req_addr_len = '0;
    bus2.req_data_len = '0; bus2.req_dummy = '0; bus2.tx_data = '0; bus2.tx_valid = '0;
    bus2.rx_ready = '0; bus2.spi_busy = 1'b0; bus2.spi_data_tx_ready = 1'b0;
    bus2.spi_data_rx = '0; bus2.spi_data_rx_valid = 1'b0;
  endtask

  task automatic set_req(input int r, input logic rd, input logic [3:0] cs, input logic [31:0] cmd,
                         input logic [31:0] addr, input logic [5:0] clen, input logic [5:0] alen,
                         input logic [15:0] dlen, input logic [15:0] dummy);
    bus.req_rd[r]              = rd;
    bus.req_cs[r*4 +: 4]       = cs;
    bus.req_cmd[r*32 +: 32]    = cmd;
    bus.req_addr[r*32 +: 32]   = addr;
    bus.req_cmd_len[r*6 +: 6]  = clen;
    bus.req_addr_len[r*6 +: 6] = alen;
    bus.req_data_len[r*16 +: 16] = dlen;
    bus.req_dummy[r*16 +: 16]  = dummy;
  endtask

  // Returns the granted requester index, or -1 if no accept pulse appears in time.
  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (bus.req_ready != 2'b00) begin
        g = bus.req_ready[1] ? 1 : 0;
        break;
      end
    end
  endtask

  // Called in the START cycle: models a core that stays busy for busy_len cycles.
  task automatic run_core(input int busy_len, output int n_done, output int tx0_hits,
                          output logic [1:0] d, output logic e);
    n_done = 0; tx0_hits = 0; d = '0; e = 1'b0;
    bus.spi_busy = (busy_len > 0);
    for (int i = 1; i <= busy_len + 40; i++) begin
      @(negedge HCLK);
      if (bus.tx_ready[0]) tx0_hits++;
      bus.spi_busy = (i < busy_len);
      if (bus.done != 2'b00) begin
        n_done++;
        d = bus.done;
        e = bus.done_err;
        break;
      end
    end
    bus.spi_busy = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_bus();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    check_val("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    check_val("rst_done", {62'd0, bus.done}, 64'd0);
    check_val("rst_spi_rd_wr", {62'd0, bus.spi_rd, bus.spi_wr}, 64'd0);
    check_val("rst_spi_cmd", {32'd0, bus.spi_cmd}, 64'd0);
    check_val("rst_swrst", {63'd0, bus2.spi_swrst}, 64'd0);
    HRESET = 1'b0;

    // Both requesters held valid: alternation starting with requester 0.
    set_req(0, 1'b1, 4'b0001, 32'h0000_0003, 32'h0000_1000, 6'd8, 6'd24, 16'd4, 16'd0);
    set_req(1, 1'b0, 4'b0010, 32'h0000_0002, 32'h0000_2000, 6'd8, 6'd24, 16'd4, 16'd0);
    bus.req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(idx);
      check_val($sformatf("rr_order_%0d", t), 64'(idx), 64'(t % 2));
      if (t == 3) bus.req_valid = 2'b00;
      @(negedge HCLK);
      run_core(3, nd, hits, dn, err);
      check_val($sformatf("rr_done_%0d", t), {62'd0, dn}, (t % 2 == 0) ? 64'd1 : 64'd2);
      $display("xfer rr%0d: grant=%0d done=%b err=%0d", t, idx, dn, err);
    end

    // Requester 1 write while requester 0 also offers TX data.
    set_req(1, 1'b0, 4'b0100, 32'h0000_0002, 32'h00AB_CDEF, 6'd8, 6'd24, 16'd16, 16'd6);
    bus.tx_data = {32'hDEAD_BEEF, 32'h0000_5555};
    bus.tx_valid = 2'b11;
    bus.spi_data_tx_ready = 1'b1;
    bus.req_valid = 2'b10;
    wait_grant(idx);
    check_val("wr_grant", 64'(idx), 64'd1);
    bus.req_valid = 2'b00;
    @(negedge HCLK);
    check_val("wr_rd_wr", {62'd0, bus.spi_rd, bus.spi_wr}, 64'd1);
    check_val("wr_dummy", {32'd0, bus.spi_dummy_rd, bus.spi_dummy_wr}, 64'h0000_0006);
    check_val("wr_csreg", {60'd0, bus.spi_csreg}, 64'h4);
    check_val("wr_tx_data", {32'd0, bus.spi_data_tx}, 64'hDEAD_BEEF);
    check_val("wr_tx_valid", {63'd0, bus.spi_data_tx_valid}, 64'd1);
    check_val("wr_tx_ready", {62'd0, bus.tx_ready}, 64'd2);
    run_core(5, nd, hits, dn, err);
    check_val("wr_tx0_never", 64'(hits), 64'd0);
    check_val("wr_done", {62'd0, dn}, 64'd2);
    $display("xfer wr: grant=%0d done=%b err=%0d", idx, dn, err);
    @(negedge HCLK);
    check_val("wr_tx_idle", {61'd0, bus.tx_ready, bus.spi_data_tx_valid}, 64'd0);
    bus.tx_valid = 2'b00;
    bus.spi_data_tx_ready = 1'b0;

    // Requester 0 read, busy for 20 cycles, RX path exercised in START.
    set_req(0, 1'b1, 4'b0001, 32'h0000_000B, 32'h0012_3456, 6'd8, 6'd24, 16'd4, 16'd8);
    bus.req_valid = 2'b01;
    wait_grant(idx);
    check_val("rd_grant", 64'(idx), 64'd0);
    bus.req_valid = 2'b00;
    @(negedge HCLK);
    check_val("rd_rd_wr", {62'd0, bus.spi_rd, bus.spi_wr}, 64'd2);
    check_val("rd_cmd", {32'd0, bus.spi_cmd}, 64'h0B);
    check_val("rd_addr", {32'd0, bus.spi_addr}, 64'h0012_3456);
    check_val("rd_lens", {36'd0, bus.spi_cmd_len, bus.spi_addr_len, bus.spi_data_len},
              {36'd0, 6'd8, 6'd24, 16'd4});
    check_val("rd_dummy", {32'd0, bus.spi_dummy_rd, bus.spi_dummy_wr}, 64'h0008_0000);
    bus.spi_data_rx = 32'hCAFE_BABE;
    bus.spi_data_rx_valid = 1'b1;
    bus.rx_ready = 2'b01;
    #1;
    check_val("rd_rx", {29'd0, bus.rx_valid, bus.spi_data_rx_ready, bus.rx_data},
              {29'd0, 2'b01, 1'b1, 32'hCAFE_BABE});
    run_core(20, nd, hits, dn, err);
    check_val("rd_done", {61'd0, dn, err}, {61'd0, 2'b01, 1'b0});
    $display("xfer rd: grant=%0d done=%b err=%0d", idx, dn, err);
    @(negedge HCLK);
    check_val("rd_rd_once", {61'd0, bus.done, bus.spi_rd}, 64'd0);
    check_val("rd_rx_idle", {62'd0, bus.rx_valid}, 64'd0);
    check_val("rd_cmd_hold", {32'd0, bus.spi_cmd}, 64'h0B);
    bus.spi_data_rx_valid = 1'b0;
    bus.rx_ready = 2'b00;

    // Reset in the middle of a transfer, then a fresh request.
    set_req(0, 1'b0, 4'b1000, 32'h0000_0032, 32'h0000_0040, 6'd8, 6'd24, 16'd2, 16'd3);
    bus.req_valid = 2'b01;
    wait_grant(idx);
    bus.req_valid = 2'b00;
    @(negedge HCLK);
    bus.spi_busy = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    check_val("mr_setup_zero", {bus.spi_cmd, bus.spi_dummy_wr, bus.spi_csreg, 12'd0}, 64'd0);
    check_val("mr_pulses_zero", {59'd0, bus.done, bus.spi_wr, bus.spi_rd, bus.spi_swrst}, 64'd0);
    HRESET = 1'b0;
    bus.spi_busy = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (bus.done != 2'b00) nd++;
    end
    check_val("mr_no_done", 64'(nd), 64'd0);
    set_req(1, 1'b1, 4'b0010, 32'h0000_009F, 32'h0, 6'd8, 6'd0, 16'd3, 16'd0);
    bus.req_valid = 2'b10;
    wait_grant(idx);
    check_val("mr_regrant", 64'(idx), 64'd1);
    bus.req_valid = 2'b00;
    @(negedge HCLK);
    check_val("mr_rd_pulse", {63'd0, bus.spi_rd}, 64'd1);
    run_core(2, nd, hits, dn, err);
    check_val("mr_done", {61'd0, dn, err}, {61'd0, 2'b10, 1'b0});
    $display("xfer after_reset: grant=%0d done=%b err=%0d", idx, dn, err);

    // Watchdog on the TIMEOUT=16 instance with the core stuck busy.
    bus2.req_rd = 2'b01;
    bus2.req_cmd = 64'h0000_0000_0000_0003;
    bus2.req_valid = 2'b01;
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (bus2.req_ready != 2'b00) begin
        idx = bus2.req_ready[1] ? 1 : 0;
        break;
      end
    end
    check_val("to_grant", 64'(idx), 64'd0);
    bus2.req_valid = 2'b00;
    @(negedge HCLK);
    check_val("to_rd_pulse", {63'd0, bus2.spi_rd}, 64'd1);
    bus2.spi_busy = 1'b1;
    sw_k = -1; sw_cnt = 0; dn_k = -1; err2 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge HCLK);
      if (bus2.spi_swrst) begin
        sw_cnt++;
        if (sw_k < 0) sw_k = k;
      end
      if (bus2.done[0] && dn_k < 0) begin
        dn_k = k;
        err2 = bus2.done_err;
      end
    end
    bus2.spi_busy = 1'b0;
    check_val("to_swrst_at", 64'(sw_k), 64'd17);
    check_val("to_swrst_cnt", 64'(sw_cnt), 64'd1);
    check_val("to_done_at", 64'(dn_k), 64'd17);
    check_val("to_done_err", {63'd0, err2}, 64'd1);
    $display("xfer timeout: swrst_cycle=%0d done_cycle=%0d err=%0d", sw_k, dn_k, err2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
